// File: rtl/adder_sched_pkg.sv
// adder_sched_pkg: shared types for the shared nibble adder.
// State encoding and slice width used by the scheduler.
package adder_sched_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_RESP
  } state_t;

endpackage

// File: rtl/cla_nibble_cin.sv
// cla_nibble_cin: 4-bit carry-look-ahead slice with carry-in.
// Purely combinational; all carries flattened from g/p and Cin.
module cla_nibble_cin (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = A & B;
  assign w_p = A ^ B;

  assign w_c[0] = Cin;
  assign w_c[1] = w_g[0]
                | (w_p[0] & Cin);
  assign w_c[2] = w_g[1]
                | (w_p[1] & w_g[0])
                | (w_p[1] & w_p[0] & Cin);
  assign w_c[3] = w_g[2]
                | (w_p[2] & w_g[1])
                | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & Cin);
  assign w_c[4] = w_g[3]
                | (w_p[3] & w_g[2])
                | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & Cin);

  assign Sum  = w_p ^ w_c[3:0];
  assign Cout = w_c[4];

endmodule

// File: rtl/adder_share_scheduler.sv
// adder_share_scheduler: round-robin shared multi-word adder.
// One CLA nibble slice, one nibble per clock, LSB nibble first.
module adder_share_scheduler
  import adder_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*WIDTH-1:0]     req_A,
  input  logic [NREQ*WIDTH-1:0]     req_B,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [WIDTH-1:0]          rsp_Sum,
  output logic                      rsp_Cout,
  output logic                      busy
);

  localparam int IDW  = $clog2(NREQ);
  localparam int NNIB = WIDTH / NIBBLE;
  localparam int IXW  = (NNIB > 1) ? $clog2(NNIB) : 1;

  state_t           r_state;
  logic [IDW-1:0]   r_ptr;
  logic [WIDTH-1:0] r_A;
  logic [WIDTH-1:0] r_B;
  logic [IXW-1:0]   r_idx;
  logic             r_carry;

  logic             w_any;
  logic [IDW-1:0]   w_grant;
  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [3:0]       w_sum;
  logic             w_cout;

  // circular scan from the pointer; lowest offset wins
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(r_ptr) + k) % NREQ]) begin
        w_any   = 1'b1;
        w_grant = IDW'((int'(r_ptr) + k) % NREQ);
      end
    end
  end

  assign req_ready = (!rst && r_state == S_IDLE && w_any)
                   ? (NREQ'(1) << w_grant)
                   : '0;

  assign w_a_nib = r_A[NIBBLE*r_idx +: NIBBLE];
  assign w_b_nib = r_B[NIBBLE*r_idx +: NIBBLE];

  cla_nibble_cin u_slice (
    .A    (w_a_nib),
    .B    (w_b_nib),
    .Cin  (r_carry),
    .Sum  (w_sum),
    .Cout (w_cout)
  );

  // sequencer: accept, nibble-serial add, hold result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_A       <= '0;
      r_B       <= '0;
      r_idx     <= '0;
      r_carry   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_Sum   <= '0;
      rsp_Cout  <= 1'b0;
      rsp_id    <= '0;
      busy      <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_A     <= req_A[int'(w_grant)*WIDTH +: WIDTH];
            r_B     <= req_B[int'(w_grant)*WIDTH +: WIDTH];
            rsp_id  <= w_grant;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_ptr   <= (w_grant == IDW'(NREQ - 1))
                     ? '0 : w_grant + 1'b1;
            busy    <= 1'b1;
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          rsp_Sum[NIBBLE*r_idx +: NIBBLE] <= w_sum;
          r_carry <= w_cout;
          r_idx   <= r_idx + 1'b1;
          if (r_idx == IXW'(NNIB - 1)) begin
            rsp_Cout  <= w_cout;
            rsp_valid <= 1'b1;
            r_state   <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/adder_share_scheduler.md
# adder_share_scheduler

Sequenced, shared multi-word adder. Accepts WIDTH-bit add requests from NREQ independent requesters and arbitrates among them round-robin. Executes each granted request on a single 4-bit carry-look-ahead nibble slice, one nibble per clock, least significant nibble first, chaining the carry between cycles. Sits between requesting datapath blocks and the one physical adder slice, so that several clients share one adder at the cost of WIDTH/4 cycles per operation.

## Interface
- NREQ, 4, number of requesters; must be ≥2.
- WIDTH, 16, operand width in bits; must be a multiple of 4 and ≥4.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_A  in  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_B  in  NREQ*WIDTH  operand B; same packing as req_A.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  result consumer accepts.
- rsp_id  out  $clog2(NREQ)  index of the requester whose result is presented.
- rsp_Sum  out  WIDTH  A+B modulo 2^WIDTH.
- rsp_Cout  out  1  carry out of the most significant bit.
- busy  out  1  high in S_ADD and S_RESP.

## Operation
- States: S_IDLE, S_ADD, S_RESP. Reset → S_IDLE.
- Reset values: rsp_valid=0, rsp_Sum=0, rsp_Cout=0, rsp_id=0, busy=0, round-robin pointer=0. req_ready is forced to 0 while rst=1.
- S_IDLE:
  - The grant is the first valid requester scanning upward, circularly, from the pointer.
  - req_ready[grant]=1, combinationally, only in this state.
  - On the accept edge: latch A, B and id; set nibble index=0 and carry=0; set pointer=(grant+1) mod NREQ; go to S_ADD.
  - With no req_valid asserted, stay in S_IDLE.
- S_ADD:
  - Each edge adds nibble[idx] of A and B plus the carry register.
  - It writes rsp_Sum[4*idx +: 4], updates the carry and increments idx.
  - At idx=WIDTH/4-1 the edge also loads rsp_Cout from the nibble carry-out and moves to S_RESP.
- S_RESP:
  - rsp_valid=1. rsp_Sum, rsp_Cout and rsp_id are held stable until handshake.
  - The edge with rsp_valid & rsp_ready moves to S_IDLE.
- req_ready is 0 in S_ADD and S_RESP. Requesters hold req_valid and operands until accepted. A deasserted req_valid is simply skipped in arbitration.
- Reset mid-operation: the in-flight operation is discarded with no response. Outputs return to reset values on that edge.
- Width rule: the full result is {rsp_Cout, rsp_Sum} = A + B, unsigned. There is no carry-in from the requester.

## Timing
- Accept at edge k → rsp_valid rises at edge k+WIDTH/4. For WIDTH=16 that is 4 edges later.
- Response handshake at edge r → S_IDLE. The earliest next accept is edge r+1, so there is one idle cycle between operations.
- Back-to-back throughput: one result per WIDTH/4+2 cycles when rsp_ready is held high.
- rsp_ready may be high before rsp_valid; this has no effect outside S_RESP.
- Simultaneous req_valid from several requesters in S_IDLE: exactly one is granted, per the pointer.

## Structure
- Package adder_sched_pkg holds:
  - state typedef enum {S_IDLE, S_ADD, S_RESP};
  - localparam NIBBLE=4.
- One sub-module, cla_nibble_cin:
  - purely combinational 4-bit carry-look-ahead adder;
  - inputs A[3:0], B[3:0], Cin; outputs Sum[3:0], Cout;
  - generate/propagate terms include Cin.
- Instantiated once; the sequencing, arbiter and result registers live in the top module.

## Test plan
- Req 0 only, A=16'h1234, B=16'h4321 → req_ready[0] for one cycle; rsp_valid 4 edges later; rsp_Sum=16'h5555, rsp_Cout=0, rsp_id=0.
- Req 1, A=16'hFFFF, B=16'h0001 → rsp_Sum=16'h0000, rsp_Cout=1. This checks carry chaining across all four nibbles.
- All four req_valid held high, rsp_ready=1 → rsp_id sequence 0,1,2,3,0. Each response is separated by 6 cycles.
- Req 2, A=16'h8000, B=16'h8000, rsp_ready low for 5 cycles after rsp_valid:
  - rsp_valid, rsp_Sum=16'h0000, rsp_Cout=1 and rsp_id=2 stay stable;
  - req_ready=0 and busy=1 throughout;
  - completion follows the first rsp_ready cycle.
- rst pulsed during S_ADD, then req 2 and req 3 valid → no response for the aborted operation; busy=0 after the reset edge; first grant is req 2 (pointer reset to 0).
